operand_bypass_scoreboard: RTL and testbench
============================================

// Module: operand_bypass_scoreboard
// PURPOSE
//  Parametrised operand bypass network for the Execute stage, with a tag/data scoreboard.
//  - Tracks the last DEPTH register-writing instructions that left E, with their results.
//  - Supplies NUM_SRC forwarded operands per cycle; youngest producer wins.
//  - Stalls E on load-use, and on a second load while one load is outstanding.
//  - Freezes when an unreturned load reaches the oldest slot.
//  - Replaces fixed 2-operand / fixed-stage forwarding and removes the separate upper-immediate path.
// PARAMETERS
//  XLEN        32  datapath width
//  NUM_SRC     2   source operands per instruction in E
//  DEPTH       3   scoreboard slots (E+1 .. E+DEPTH); >=1
//  REG_ADDR_W  5   register address width
// PORTS
//  iClk        in   1                  clock, rising edge
//  iRstN       in   1                  asynchronous, active-low reset
//  iValidE     in   1                  E holds a real instruction
//  iWrEnE      in   1                  E instruction writes rd
//  iIsLoadE    in   1                  E instruction is a load (result arrives later)
//  iRdE        in   REG_ADDR_W         E destination register
//  iResultE    in   XLEN               E final non-load result (ALU or upper-imm already muxed)
//  iFlushE     in   1                  kill E instruction (branch mispredict)
//  iRsAddrE    in   NUM_SRC*REG_ADDR_W source register addresses, src k at [k*W +: W]
//  iRegDataE   in   NUM_SRC*XLEN       register-file read data per source
//  iLoadValid  in   1                  load data returning this cycle
//  iLoadData   in   XLEN               returned load data
//  oOperand    out  NUM_SRC*XLEN       resolved operands
//  oFwdHit     out  NUM_SRC            operand k taken from the scoreboard or the load bus
//  oStall      out  1                  hold F/D/E this cycle
//  oLoadPending out 1                  a load entry is valid and not ready
// BEHAVIOUR
//  Entry fields: valid, rd, ready, data. Slot 1 is youngest; slot DEPTH is oldest.
//  Reset: all entries are cleared to invalid and not ready, and all data is zeroed.
//   - Outputs are combinational from the cleared state, so during reset oOperand == iRegDataE, oFwdHit = 0, oStall = 0, oLoadPending = 0.
//   - A pending load is dropped by reset; any later iLoadValid is ignored.
//  Lookup (combinational, same cycle) for each source k:
//   - rs == 0: operand = iRegDataE[k] and hit = 0. x0 is never forwarded.
//   - Otherwise take the lowest-numbered valid slot with rd == rs.
//   - Slot ready: operand = slot data, hit = 1.
//   - Slot is the pending load and iLoadValid = 1: operand = iLoadData, hit = 1, no stall.
//   - Slot is the pending load and iLoadValid = 0: load-use, so stall.
//   - No match: operand = iRegDataE[k].
//  oStall = iValidE & !iFlushE & (load-use on any source | (iIsLoadE & oLoadPending & !iLoadValid)) | freeze.
//  freeze = slot DEPTH valid & !ready & !iLoadValid.
//   - On freeze: no slot shifts and oStall = 1, but a load return is still captured.
//  Load return: iLoadValid writes iLoadData into the single pending entry and sets ready.
//   - iLoadValid with no pending entry is ignored.
//  Shift on each rising edge, when not frozen:
//   - slot i+1 <= slot i; slot DEPTH drops out (the register file has been written by W).
//   - The load-return update is applied to the entry as it moves.
//  Slot 1 insert:
//   - If iValidE & iWrEnE & !iFlushE & !oStall & iRdE != 0: valid = 1, rd = iRdE.
//     - ready = !iIsLoadE.
//     - data = iIsLoadE ? 0 : iResultE.
//   - Otherwise slot 1 becomes a bubble (valid = 0).
//  Precedence and corner cases:
//   - iFlushE beats stall (flushed E never stalls or inserts).
//   - Duplicate rd in slots: youngest wins.
//   - At most one load outstanding at any time.
// TESTING
//  T1 back-to-back: E writes x5 = 0x11, next E reads x5 -> oOperand0 = 0x11, hit = 1, oStall = 0.
//  T2 youngest wins: x7 = 0xA (slot 2), x7 = 0xB (slot 1), read x7 -> 0xB. A read of x0 while a slot holds rd = 0 -> regfile data.
//  T3 load-use: load x3, next E reads x3 with iLoadValid = 0 -> oStall = 1 and slot 1 gets a bubble.
//     Then iLoadValid = 1 with data 0xDEAD -> operand 0xDEAD, oStall = 0.
//  T4 freeze: load x9, no return for DEPTH+2 cycles -> slots frozen from the cycle the load reaches slot DEPTH.
//     Return 0x55 -> captured, shifting resumes, and a later reader of x9 gets 0x55.
//  T5 flush: iFlushE on a writer of x4 = 0x99 while a load-use stall is present -> oStall = 0, x4 is not inserted, next read of x4 = regfile data.
//  T6 reset mid-operation: load pending, iRstN low for 1 cycle -> all hits = 0, oLoadPending = 0; a late iLoadValid has no effect.

Source files
------------

// File: rtl/operand_bypass_scoreboard.sv
// Execute-stage operand bypass network with a tag/data scoreboard.
// Youngest producer wins; stalls on load-use and freezes on an old unreturned load.
module operand_bypass_scoreboard #(
   parameter int XLEN       = 32,
   parameter int NUM_SRC    = 2,
   parameter int DEPTH      = 3,
   parameter int REG_ADDR_W = 5
) (
   input  logic                         iClk,
   input  logic                         iRstN,
   input  logic                         iValidE,
   input  logic                         iWrEnE,
   input  logic                         iIsLoadE,
   input  logic [REG_ADDR_W-1:0]        iRdE,
   input  logic [XLEN-1:0]              iResultE,
   input  logic                         iFlushE,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] iRsAddrE,
   input  logic [NUM_SRC*XLEN-1:0]      iRegDataE,
   input  logic                         iLoadValid,
   input  logic [XLEN-1:0]              iLoadData,
   output logic [NUM_SRC*XLEN-1:0]      oOperand,
   output logic [NUM_SRC-1:0]           oFwdHit,
   output logic                         oStall,
   output logic                         oLoadPending
);

   typedef struct packed {
      logic                  valid;
      logic                  ready;
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } entry_t;

   entry_t             slot_q [1:DEPTH];
   entry_t             upd    [1:DEPTH];
   entry_t             ins;
   logic [NUM_SRC-1:0] luse;
   logic               pending;
   logic               freeze;
   logic               ldstall;
   logic               insert;

   // Find the single pending load and apply a returning load to it
   always_comb begin
      pending = 1'b0;
      for (int i = 1; i <= DEPTH; i++) begin
         upd[i] = slot_q[i];
         if (slot_q[i].valid && !slot_q[i].ready) begin
            pending = 1'b1;
            if (iLoadValid) begin
               upd[i].ready = 1'b1;
               upd[i].data  = iLoadData;
            end
         end
      end
   end

   // Per-source lookup; scanning oldest to youngest lets the youngest match win
   always_comb begin
      oOperand = iRegDataE;
      oFwdHit  = '0;
      luse     = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         for (int i = DEPTH; i >= 1; i--) begin
            if (iRsAddrE[k*REG_ADDR_W +: REG_ADDR_W] != '0 &&
                slot_q[i].valid &&
                slot_q[i].rd == iRsAddrE[k*REG_ADDR_W +: REG_ADDR_W]) begin
               if (slot_q[i].ready) begin
                  oOperand[k*XLEN +: XLEN] = slot_q[i].data;
                  oFwdHit[k]               = 1'b1;
                  luse[k]                  = 1'b0;
               end else if (iLoadValid) begin
                  oOperand[k*XLEN +: XLEN] = iLoadData;
                  oFwdHit[k]               = 1'b1;
                  luse[k]                  = 1'b0;
               end else begin
                  oOperand[k*XLEN +: XLEN] = iRegDataE[k*XLEN +: XLEN];
                  oFwdHit[k]               = 1'b0;
                  luse[k]                  = 1'b1;
               end
            end
         end
      end
   end

   assign freeze = slot_q[DEPTH].valid & ~slot_q[DEPTH].ready & ~iLoadValid;
   assign ldstall = iIsLoadE & pending & ~iLoadValid;
   assign oStall = (iValidE & ~iFlushE & ((|luse) | ldstall)) | freeze;
   assign oLoadPending = pending;
   assign insert = iValidE & iWrEnE & ~iFlushE & ~oStall & (iRdE != '0);

   // Build the new youngest entry, or a bubble
   always_comb begin
      ins = '0;
      if (insert) begin
         ins.valid = 1'b1;
         ins.rd    = iRdE;
         ins.ready = ~iIsLoadE;
         ins.data  = iIsLoadE ? '0 : iResultE;
      end
   end

   // Shift the scoreboard each cycle unless an unreturned load sits in the oldest slot
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         for (int i = 1; i <= DEPTH; i++) slot_q[i] <= '0;
      end else if (freeze) begin
         for (int i = 1; i <= DEPTH; i++) slot_q[i] <= upd[i];
      end else begin
         slot_q[1] <= ins;
         for (int i = 2; i <= DEPTH; i++) slot_q[i] <= upd[i-1];
      end
   end

endmodule

// File: tb/tb_operand_bypass_scoreboard.sv
// Directed bench for operand_bypass_scoreboard (DEPTH=3, NUM_SRC=2).
// Each task drives a scenario and checks hand-computed results.
module tb_operand_bypass_scoreboard;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        v, wr, ld, fl, lv;
   logic [4:0]  rd;
   logic [31:0] res, ldd;
   logic [9:0]  rs;
   logic [63:0] rf;
   logic [63:0] oper;
   logic [1:0]  hit;
   logic        stall, pend;
   int          vecs = 0;
   int          errs = 0;

   always #5 clk = ~clk;

   operand_bypass_scoreboard dut (
      .iClk(clk), .iRstN(rst_n), .iValidE(v), .iWrEnE(wr), .iIsLoadE(ld),
      .iRdE(rd), .iResultE(res), .iFlushE(fl), .iRsAddrE(rs), .iRegDataE(rf),
      .iLoadValid(lv), .iLoadData(ldd), .oOperand(oper), .oFwdHit(hit),
      .oStall(stall), .oLoadPending(pend)
   );

   // one E cycle: drive at negedge, settle, checks follow before the posedge
   task automatic drv(input logic iv, iwr, ild, ifl, input logic [4:0] ird,
                      input logic [31:0] ires, input logic [4:0] rs0, rs1,
                      input logic [31:0] rf0, rf1, input logic ilv,
                      input logic [31:0] ild_d);
      @(negedge clk);
      v = iv; wr = iwr; ld = ild; fl = ifl; rd = ird; res = ires;
      rs = {rs1, rs0}; rf = {rf1, rf0}; lv = ilv; ldd = ild_d;
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) drv(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      drv(1, 0, 0, 0, 0, 0, 5, 6, 32'h100, 32'h200, 0, 0);
      vecs++; if (oper !== 64'h00000200_00000100) begin errs++; $display("FAIL rst_oper got=%h exp=%h", oper, 64'h00000200_00000100); end
      vecs++; if (hit !== 2'b00) begin errs++; $display("FAIL rst_hit got=%b exp=00", hit); end
      vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL rst_stall got=%b exp=0", stall); end
      vecs++; if (pend !== 1'b0) begin errs++; $display("FAIL rst_pend got=%b exp=0", pend); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_back_to_back;
      idle(3);
      drv(1, 1, 0, 0, 5, 32'h11, 0, 0, 0, 0, 0, 0);
      vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL b2b_wr_stall got=%b exp=0", stall); end
      drv(1, 0, 0, 0, 0, 0, 5, 0, 32'hAAAA, 32'hBBBB, 0, 0);
      vecs++; if (oper !== 64'h0000BBBB_00000011) begin errs++; $display("FAIL b2b_oper got=%h exp=%h", oper, 64'h0000BBBB_00000011); end
      vecs++; if (hit !== 2'b01) begin errs++; $display("FAIL b2b_hit got=%b exp=01", hit); end
      vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL b2b_stall got=%b exp=0", stall); end
      drv(1, 0, 0, 0, 0, 0, 0, 5, 32'h1, 32'h2, 0, 0);
      vecs++; if (oper !== 64'h00000011_00000001 || hit !== 2'b10) begin errs++; $display("FAIL b2b_slot2 got=%h/%b exp=%h/10", oper, hit, 64'h00000011_00000001); end
   endtask

   task automatic test_youngest_wins;
      idle(3);
      drv(1, 1, 0, 0, 7, 32'hA, 0, 0, 0, 0, 0, 0);
      drv(1, 1, 0, 0, 7, 32'hB, 0, 0, 0, 0, 0, 0);
      drv(1, 1, 0, 0, 0, 32'h77, 0, 0, 0, 0, 0, 0);
      drv(1, 0, 0, 0, 0, 0, 7, 0, 32'h5555, 32'h1234, 0, 0);
      vecs++; if (oper !== 64'h00001234_0000000B) begin errs++; $display("FAIL yw_oper got=%h exp=%h", oper, 64'h00001234_0000000B); end
      vecs++; if (hit !== 2'b01) begin errs++; $display("FAIL yw_hit got=%b exp=01", hit); end
      drv(1, 0, 0, 0, 0, 0, 0, 7, 32'h42, 32'h43, 0, 0);
      vecs++; if (oper !== 64'h0000000B_00000042 || hit !== 2'b10) begin errs++; $display("FAIL yw_slot3 got=%h/%b exp=%h/10", oper, hit, 64'h0000000B_00000042); end
   endtask

   task automatic test_load_use;
      idle(3);
      drv(1, 1, 1, 0, 3, 32'hFFFF, 0, 0, 0, 0, 0, 0);
      vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL lu_issue_stall got=%b exp=0", stall); end
      drv(1, 1, 0, 0, 6, 32'h66, 3, 6, 32'h3030, 32'h6060, 0, 0);
      vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL lu_stall got=%b exp=1", stall); end
      vecs++; if (hit !== 2'b00 || pend !== 1'b1) begin errs++; $display("FAIL lu_hitpend got=%b/%b exp=00/1", hit, pend); end
      drv(1, 1, 0, 0, 6, 32'h66, 3, 6, 32'h3030, 32'h6060, 1, 32'hDEAD);
      vecs++; if (oper !== 64'h00006060_0000DEAD) begin errs++; $display("FAIL lu_ret_oper got=%h exp=%h", oper, 64'h00006060_0000DEAD); end
      vecs++; if (hit !== 2'b01 || stall !== 1'b0) begin errs++; $display("FAIL lu_ret_hs got=%b/%b exp=01/0", hit, stall); end
      drv(1, 0, 0, 0, 0, 0, 3, 6, 32'h1, 32'h2, 0, 0);
      vecs++; if (oper !== 64'h00000066_0000DEAD) begin errs++; $display("FAIL lu_after_oper got=%h exp=%h", oper, 64'h00000066_0000DEAD); end
      vecs++; if (hit !== 2'b11 || pend !== 1'b0) begin errs++; $display("FAIL lu_after_hp got=%b/%b exp=11/0", hit, pend); end
   endtask

   task automatic test_second_load;
      idle(3);
      drv(1, 1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
      drv(1, 1, 1, 0, 8, 0, 0, 0, 0, 0, 0, 0);
      vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL sl_stall got=%b exp=1", stall); end
      drv(1, 1, 1, 0, 8, 0, 0, 0, 0, 0, 1, 32'h33);
      vecs++; if (stall !== 1'b0 || pend !== 1'b1) begin errs++; $display("FAIL sl_ret got=%b/%b exp=0/1", stall, pend); end
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h88);
      drv(1, 0, 0, 0, 0, 0, 8, 3, 32'h1, 32'h2, 0, 0);
      vecs++; if (oper !== 64'h00000002_00000088 || hit !== 2'b01) begin errs++; $display("FAIL sl_read got=%h/%b exp=%h/01", oper, hit, 64'h00000002_00000088); end
   endtask

   task automatic test_freeze;
      idle(3);
      drv(1, 1, 1, 0, 9, 0, 0, 0, 0, 0, 0, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL fz_slot2_stall got=%b exp=0", stall); end
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drv(1, 1, 0, 0, 10, 32'h10, 9, 0, 32'h9999, 0, 0, 0);
      vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL fz_stall got=%b exp=1", stall); end
      drv(1, 1, 0, 0, 10, 32'h10, 9, 0, 32'h9999, 0, 0, 0);
      vecs++; if (stall !== 1'b1 || pend !== 1'b1) begin errs++; $display("FAIL fz_hold got=%b/%b exp=1/1", stall, pend); end
      drv(1, 1, 0, 0, 10, 32'h10, 9, 0, 32'h9999, 0, 1, 32'h55);
      vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL fz_ret_stall got=%b exp=0", stall); end
      vecs++; if (oper[31:0] !== 32'h55 || hit !== 2'b01) begin errs++; $display("FAIL fz_ret_oper got=%h/%b exp=55/01", oper[31:0], hit); end
      drv(1, 0, 0, 0, 0, 0, 10, 9, 32'h1, 32'h55, 0, 0);
      vecs++; if (oper !== 64'h00000055_00000010 || hit !== 2'b01) begin errs++; $display("FAIL fz_resume got=%h/%b exp=%h/01", oper, hit, 64'h00000055_00000010); end
      vecs++; if (pend !== 1'b0) begin errs++; $display("FAIL fz_pend got=%b exp=0", pend); end
   endtask

   task automatic test_flush;
      idle(3);
      drv(1, 1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
      drv(1, 1, 0, 1, 4, 32'h99, 3, 0, 0, 0, 0, 0);
      vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL fl_stall got=%b exp=0", stall); end
      drv(1, 0, 0, 0, 0, 0, 4, 3, 32'h4444, 32'h3333, 1, 32'h1);
      vecs++; if (oper !== 64'h00000001_00004444) begin errs++; $display("FAIL fl_oper got=%h exp=%h", oper, 64'h00000001_00004444); end
      vecs++; if (hit !== 2'b10 || stall !== 1'b0) begin errs++; $display("FAIL fl_hs got=%b/%b exp=10/0", hit, stall); end
   endtask

   task automatic test_reset_mid;
      idle(3);
      drv(1, 1, 1, 0, 12, 0, 0, 0, 0, 0, 0, 0);
      drv(0, 0, 0, 0, 0, 0, 12, 0, 32'hC0C0, 0, 0, 0);
      vecs++; if (pend !== 1'b1) begin errs++; $display("FAIL rm_pend_before got=%b exp=1", pend); end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      vecs++; if (pend !== 1'b0 || hit !== 2'b00) begin errs++; $display("FAIL rm_in_reset got=%b/%b exp=0/00", pend, hit); end
      vecs++; if (oper !== 64'h00000000_0000C0C0) begin errs++; $display("FAIL rm_oper got=%h exp=%h", oper, 64'h00000000_0000C0C0); end
      @(negedge clk);
      rst_n = 1'b1;
      drv(1, 0, 0, 0, 0, 0, 12, 0, 32'h1212, 0, 1, 32'hBEEF);
      vecs++; if (oper[31:0] !== 32'h1212 || hit !== 2'b00) begin errs++; $display("FAIL rm_late_ret got=%h/%b exp=1212/00", oper[31:0], hit); end
      drv(1, 0, 0, 0, 0, 0, 12, 0, 32'h1313, 0, 0, 0);
      vecs++; if (oper[31:0] !== 32'h1313 || hit !== 2'b00 || pend !== 1'b0) begin errs++; $display("FAIL rm_after got=%h/%b/%b exp=1313/00/0", oper[31:0], hit, pend); end
   endtask

   initial begin
      v = 0; wr = 0; ld = 0; fl = 0; lv = 0; rd = 0; res = 0; ldd = 0; rs = 0; rf = 0;
      test_reset;
      test_back_to_back;
      test_youngest_wins;
      test_load_use;
      test_second_load;
      test_freeze;
      test_flush;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
